burst_memory_responder: RTL and testbench
=========================================

# burst_memory_responder

Memory-side responder for the 4-beat, 64-bit burst protocol that the cache line adaptor drives toward main memory. It accepts a line read or write request, waits a programmable access latency, then streams or absorbs four beats while asserting the response. It serves as a synthesizable line-store memory model for cache/adaptor integration and as the reference responder in the memory-subsystem testbench.

## Interface
- DEPTH_LINES, 16: number of 256-bit lines stored; power of two, minimum 2.
- LATENCY, 4: wait cycles between request acceptance and the first response beat; minimum 1.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-high reset.
- read_i  input  1  line read request; held high by the initiator until the burst completes.
- write_i  input  1  line write request; held high by the initiator until the burst completes.
- address_i  input  32  line address; bits [4:0] ignored; index = address_i[5+log2(DEPTH_LINES)-1:5]; upper bits ignored, so addresses alias modulo DEPTH_LINES.
- burst_i  input  64  write beat data from the initiator.
- burst_o  output  64  read beat data, registered.
- resp_o  output  1  beat-valid / response strobe, registered.
- protocol_err  output  1  sticky flag; set when a request drops during WAIT or BURST.

## Operation
- Storage: DEPTH_LINES x 256 bits, cleared to zero by reset. Beat k maps to line bits [64k+63:64k], beat 0 first.
- States: IDLE, WAIT, BURST, DONE.
- IDLE: if read_i is high, accept a read; else if write_i is high, accept a write. Read wins when both are high. On accept, latch the index and the op, load the wait counter with LATENCY, and go to WAIT.
- WAIT: decrement the counter each cycle. When it reaches 1, go to BURST with beat counter = 0.
- BURST: exactly 4 cycles, beat counter 0..3.
  - Read: resp_o=1 and burst_o = stored beat k.
  - Write: resp_o=1, and burst_i is written into beat k of the latched line at the end of that cycle.
  - After beat 3, go to DONE.
- DONE: resp_o=0. Stay in DONE while read_i or write_i is high; go to IDLE when both are low. A new request is never accepted until both have been observed low.
- Request dropped during WAIT or BURST (protocol violation): the transaction still completes in full, and write beats are still committed. protocol_err is set and stays set until reset.
- The address is latched at accept. Changes to address_i mid-transaction are ignored.

## Timing
- Reset (asynchronous, immediate): state=IDLE, resp_o=0, burst_o=0, protocol_err=0, counters=0, storage=0. Reset mid-transaction abandons it, and no further beats are written.
- Request first high in cycle 0 (sampled at the end of cycle 0):
  - Cycles 1..LATENCY: WAIT, resp_o=0, burst_o=0.
  - Cycles LATENCY+1..LATENCY+4: BURST, resp_o=1.
  - Cycle LATENCY+5: DONE, or IDLE in cycle LATENCY+6 if the request is already low.
- resp_o is high for exactly 4 consecutive cycles per transaction and is never high outside BURST.
- burst_o is 0 in every cycle except read BURST cycles.
- Read-after-write to the same line: the read returns the new data. Storage is updated at the edge ending each write beat, and reads are issued later.
- Minimum request-to-request spacing is LATENCY+6 cycles.

## Test plan
- Reset then read line 3 with LATENCY=4 -> resp_o high in cycles 5..8, burst_o=0 on all four beats, protocol_err=0.
- Write address 0x0000_0060 with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44, then read the same address -> read beats return 0x11..11, 0x22..22, 0x33..33, 0x44..44 in that order, and resp_o is high for exactly 4 cycles each time.
- Aliasing with DEPTH_LINES=16: write address 0x0000_0020, then read address 0x0000_0220 -> returns the written data.
- read_i and write_i high together in IDLE -> a read is performed, and storage is unchanged.
- Request held high for 3 cycles after beat 3 -> the responder stays in DONE with resp_o=0 and no second transaction starts. Dropping the request -> IDLE next cycle, and a new request is accepted.
- Drop write_i after beat 1, then assert reset mid-WAIT on the following request:
  - All 4 write beats are committed and protocol_err=1.
  - Reset clears protocol_err, resp_o and storage immediately.

Source files
------------

// File: rtl/burst_memory_responder_if.sv
// -----------------------------------------------------------------------------
// burst_memory_responder_if
//
// Purpose: bundles the request/response signals of the 4-beat, 64-bit line
// burst protocol between an initiator (cache line adaptor) and the memory
// responder.
//
// Signals:
//   read_i       initiator -> responder  line read request, held until done
//   write_i      initiator -> responder  line write request, held until done
//   address_i    initiator -> responder  32-bit line address (bits [4:0] unused)
//   burst_i      initiator -> responder  64-bit write beat data
//   burst_o      responder -> initiator  64-bit read beat data
//   resp_o       responder -> initiator  beat-valid strobe
//   protocol_err responder -> initiator  sticky request-drop flag
//
// Modports: master (initiator side), slave (responder side).
// -----------------------------------------------------------------------------
interface burst_memory_responder_if;
    logic        read_i;
    logic        write_i;
    logic [31:0] address_i;
    logic [63:0] burst_i;
    logic [63:0] burst_o;
    logic        resp_o;
    logic        protocol_err;

    modport master (
        output read_i,
        output write_i,
        output address_i,
        output burst_i,
        input  burst_o,
        input  resp_o,
        input  protocol_err
    );

    modport slave (
        input  read_i,
        input  write_i,
        input  address_i,
        input  burst_i,
        output burst_o,
        output resp_o,
        output protocol_err
    );
endinterface

// File: rtl/burst_memory_responder.sv
// -----------------------------------------------------------------------------
// burst_memory_responder
//
// Purpose: memory-side responder for the 4-beat, 64-bit line burst protocol.
// Accepts a line read or write, waits LATENCY cycles, then streams (read) or
// absorbs (write) four beats while asserting resp_o. Line storage is a
// register array cleared by reset, so it doubles as a line-store model.
//
// Parameters:
//   DEPTH_LINES  number of 256-bit lines (power of two, >= 2)
//   LATENCY      wait cycles between accept and first beat (>= 1)
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    burst protocol interface, slave modport
// -----------------------------------------------------------------------------
module burst_memory_responder #(
    parameter int DEPTH_LINES = 16,
    parameter int LATENCY     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    burst_memory_responder_if.slave   bus
);

    localparam int IDX_W = $clog2(DEPTH_LINES);
    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST,
        DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [1:0]         beat_reg, beat_next;
    logic [IDX_W-1:0]   index_reg, index_next;
    logic               op_read_reg, op_read_next;
    logic               err_reg, err_next;
    logic               resp_reg, resp_next;
    logic [63:0]        data_reg, data_next;
    logic               write_en;
    logic               req_dropped;

    // All lines packed into one flat vector: line i occupies bits
    // [256*i +: 256], beat k of that line sits at [256*i + 64*k +: 64],
    // so {index, beat, 6'b0} is the bit offset of any beat.
    logic [DEPTH_LINES*256-1:0] store_flat;

    // Address bits outside the line index are deliberately ignored
    // (lines alias modulo DEPTH_LINES).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.address_i[31:5+IDX_W], bus.address_i[4:0]};

    // A violation is the accepted request's own strobe going low; for a read
    // accepted with write_i also high, write_i dropping is harmless.
    assign req_dropped = op_read_reg ? !bus.read_i : !bus.write_i;

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        beat_next    = beat_reg;
        index_next   = index_reg;
        op_read_next = op_read_reg;
        err_next     = err_reg;
        resp_next    = 1'b0;
        data_next    = '0;
        write_en     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.read_i || bus.write_i) begin
                    op_read_next = bus.read_i;   // read wins when both high
                    index_next   = bus.address_i[5 +: IDX_W];
                    count_next   = CNT_W'(LATENCY);
                    state_next   = WAIT;
                end
            end
            WAIT: begin
                if (req_dropped) begin
                    err_next = 1'b1;
                end
                count_next = count_reg - CNT_W'(1);
                if (count_reg == CNT_W'(1)) begin
                    beat_next  = 2'd0;
                    state_next = BURST;
                end
            end
            BURST: begin
                if (req_dropped) begin
                    err_next = 1'b1;
                end
                // Write beats commit even after a dropped request.
                write_en = !op_read_reg;
                if (beat_reg == 2'd3) begin
                    state_next = DONE;
                end else begin
                    beat_next = beat_reg + 2'd1;
                end
            end
            DONE: begin
                if (!bus.read_i && !bus.write_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Outputs are registered, so they are computed for the state being
        // entered: a beat presented in BURST cycle k is fetched at the edge
        // that starts that cycle.
        if (state_next == BURST) begin
            resp_next = 1'b1;
            if (op_read_next) begin
                data_next = store_flat[{index_next, beat_next, 6'd0} +: 64];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Control and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            beat_reg    <= '0;
            index_reg   <= '0;
            op_read_reg <= 1'b0;
            err_reg     <= 1'b0;
            resp_reg    <= 1'b0;
            data_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            beat_reg    <= beat_next;
            index_reg   <= index_next;
            op_read_reg <= op_read_next;
            err_reg     <= err_next;
            resp_reg    <= resp_next;
            data_reg    <= data_next;
        end
    end

    // -------------------------------------------------------------------------
    // Line storage: one register per line, cleared by reset
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH_LINES; gi++) begin : g_line
            logic [255:0] line_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    line_reg <= '0;
                end else if (write_en && (index_reg == IDX_W'(gi))) begin
                    line_reg[{beat_reg, 6'd0} +: 64] <= bus.burst_i;
                end
            end

            assign store_flat[gi*256 +: 256] = line_reg;
        end
    endgenerate

    assign bus.burst_o      = data_reg;
    assign bus.resp_o       = resp_reg;
    assign bus.protocol_err = err_reg;

endmodule

// File: tb/tb_burst_memory_responder.sv
// -----------------------------------------------------------------------------
// tb_burst_memory_responder
//
// Directed bench for burst_memory_responder (DEPTH_LINES=16, LATENCY=4).
// Inputs are driven 1 time unit after the rising edge; registered outputs are
// sampled at the same point, so each step() lands in the next clock cycle.
// -----------------------------------------------------------------------------
module tb_burst_memory_responder;

    localparam int LAT = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    burst_memory_responder_if bus();

    burst_memory_responder #(
        .DEPTH_LINES (16),
        .LATENCY     (LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [63:0] wdata [4];
    logic [63:0] rdata [4];
    logic [63:0] expd  [4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction starting in the current cycle (cycle 0).
    // drop_after >= 0 lowers the requests from beat drop_after+1 onward;
    // hold keeps the request high for that many extra cycles in DONE.
    task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                       input int drop_after, input int hold);
        bus.read_i    = rd;
        bus.write_i   = wr;
        bus.address_i = addr;
        bus.burst_i   = '0;
        for (int c = 1; c <= LAT; c++) begin
            step();
            // address must be latched at accept; wiggle it to another line
            bus.address_i = addr ^ 32'h0000_0040;
            check("wait_resp", 64'(bus.resp_o), 64'd0);
            check("wait_data", bus.burst_o, 64'd0);
        end
        for (int b = 0; b < 4; b++) begin
            step();
            if (drop_after >= 0 && b > drop_after) begin
                bus.read_i  = 1'b0;
                bus.write_i = 1'b0;
            end
            bus.burst_i = wdata[b];
            check("beat_resp", 64'(bus.resp_o), 64'd1);
            rdata[b] = bus.burst_o;
            if (!rd) begin
                check("write_beat_data", bus.burst_o, 64'd0);
            end
        end
        step();
        check("done_resp", 64'(bus.resp_o), 64'd0);
        check("done_data", bus.burst_o, 64'd0);
        for (int h = 0; h < hold; h++) begin
            step();
            check("hold_resp", 64'(bus.resp_o), 64'd0);
            check("hold_data", bus.burst_o, 64'd0);
        end
        bus.read_i  = 1'b0;
        bus.write_i = 1'b0;
        bus.burst_i = '0;
        step();
        check("idle_resp", 64'(bus.resp_o), 64'd0);
    endtask

    task automatic check_read(input string tag);
        for (int b = 0; b < 4; b++) begin
            check(tag, rdata[b], expd[b]);
            $display("read %s beat%0d data=%h expected=%h", tag, b, rdata[b], expd[b]);
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.read_i    = 1'b0;
        bus.write_i   = 1'b0;
        bus.address_i = '0;
        bus.burst_i   = '0;
        for (int b = 0; b < 4; b++) wdata[b] = '0;

        // Reset state
        step();
        step();
        check("reset_resp", 64'(bus.resp_o), 64'd0);
        check("reset_data", bus.burst_o, 64'd0);
        check("reset_err", 64'(bus.protocol_err), 64'd0);
        reset = 1'b0;
        step();

        // Read line 3 after reset: zeros
        txn(1'b1, 1'b0, 32'h0000_0060, -1, 0);
        for (int b = 0; b < 4; b++) expd[b] = 64'd0;
        check_read("rd_line3_reset");
        check("rd_line3_err", 64'(bus.protocol_err), 64'd0);

        // Write line 3 then read it back
        wdata[0] = 64'h1111_1111_1111_1111;
        wdata[1] = 64'h2222_2222_2222_2222;
        wdata[2] = 64'h3333_3333_3333_3333;
        wdata[3] = 64'h4444_4444_4444_4444;
        txn(1'b0, 1'b1, 32'h0000_0060, -1, 0);
        $display("write addr=00000060 done");
        txn(1'b1, 1'b0, 32'h0000_0060, -1, 0);
        expd[0] = 64'h1111_1111_1111_1111;
        expd[1] = 64'h2222_2222_2222_2222;
        expd[2] = 64'h3333_3333_3333_3333;
        expd[3] = 64'h4444_4444_4444_4444;
        check_read("raw_line3");

        // Aliasing: write 0x20 (line 1), read 0x220 (also line 1)
        wdata[0] = 64'hA1A1_0000_0000_0001;
        wdata[1] = 64'hA2A2_0000_0000_0002;
        wdata[2] = 64'hA3A3_0000_0000_0003;
        wdata[3] = 64'hA4A4_0000_0000_0004;
        txn(1'b0, 1'b1, 32'h0000_0020, -1, 0);
        $display("write addr=00000020 done");
        txn(1'b1, 1'b0, 32'h0000_0220, -1, 0);
        for (int b = 0; b < 4; b++) expd[b] = wdata[b];
        check_read("alias_line1");

        // Read and write together: read wins, storage untouched
        wdata[0] = 64'hDEAD_BEEF_0000_0000;
        wdata[1] = 64'hDEAD_BEEF_1111_1111;
        wdata[2] = 64'hDEAD_BEEF_2222_2222;
        wdata[3] = 64'hDEAD_BEEF_3333_3333;
        txn(1'b1, 1'b1, 32'h0000_0060, -1, 0);
        expd[0] = 64'h1111_1111_1111_1111;
        expd[1] = 64'h2222_2222_2222_2222;
        expd[2] = 64'h3333_3333_3333_3333;
        expd[3] = 64'h4444_4444_4444_4444;
        check_read("both_high_read");
        for (int b = 0; b < 4; b++) wdata[b] = '0;
        txn(1'b1, 1'b0, 32'h0000_0060, -1, 0);
        check_read("both_high_unchanged");
        check("both_high_err", 64'(bus.protocol_err), 64'd0);

        // Request held 3 cycles in DONE: no restart, then new request accepted
        txn(1'b1, 1'b0, 32'h0000_0020, -1, 3);
        expd[0] = 64'hA1A1_0000_0000_0001;
        expd[1] = 64'hA2A2_0000_0000_0002;
        expd[2] = 64'hA3A3_0000_0000_0003;
        expd[3] = 64'hA4A4_0000_0000_0004;
        check_read("hold_read");
        txn(1'b1, 1'b0, 32'h0000_0020, -1, 0);
        check_read("after_hold_read");

        // Write to line 2 with write_i dropped after beat 1
        wdata[0] = 64'h5555_5555_5555_5555;
        wdata[1] = 64'h6666_6666_6666_6666;
        wdata[2] = 64'h7777_7777_7777_7777;
        wdata[3] = 64'h8888_8888_8888_8888;
        txn(1'b0, 1'b1, 32'h0000_0040, 1, 0);
        $display("write addr=00000040 dropped after beat1");
        check("drop_err_set", 64'(bus.protocol_err), 64'd1);
        for (int b = 0; b < 4; b++) expd[b] = wdata[b];
        for (int b = 0; b < 4; b++) wdata[b] = '0;
        txn(1'b1, 1'b0, 32'h0000_0040, -1, 0);
        check_read("drop_committed");
        check("drop_err_sticky", 64'(bus.protocol_err), 64'd1);

        // Reset asserted mid-WAIT of the next request
        bus.read_i    = 1'b1;
        bus.address_i = 32'h0000_0060;
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_err", 64'(bus.protocol_err), 64'd0);
        check("async_rst_resp", 64'(bus.resp_o), 64'd0);
        check("async_rst_data", bus.burst_o, 64'd0);
        $display("reset asserted mid-WAIT");
        bus.read_i = 1'b0;
        step();
        reset = 1'b0;
        step();

        // Storage cleared by reset
        for (int b = 0; b < 4; b++) expd[b] = 64'd0;
        txn(1'b1, 1'b0, 32'h0000_0060, -1, 0);
        check_read("cleared_line3");
        txn(1'b1, 1'b0, 32'h0000_0040, -1, 0);
        check_read("cleared_line2");
        check("final_err", 64'(bus.protocol_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
